mem_port_arbiter: RTL and testbench

Sequences and shares one single-port unified memory between instruction fetch (IF stage) and data access (MEM stage) of the 5-stage RISC-V pipeline. Data requests take priority. Loads and fetches wait for a variable-latency memory response. The block drives per-requester stall signals so the hazard logic can freeze PC, IF/ID and the later stage registers.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter_lat_timer.sv | 37 +++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
//   arb_state_t : arbiter sequencing states
//   mem_req_t   : request fields latched at issue and replayed while waiting
//   FETCH_FUNC3 : access size presented to memory for instruction fetches
package mem_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 9;
  localparam int unsigned ARB_DATA_W = 32;

  // Instruction fetches are always full-word reads.
  localparam logic [2:0] FETCH_FUNC3 = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_WAIT,
    LOAD_WAIT
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [2:0]            func3;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/MEM requesters, the arbiter and the
// single-port memory.
//   slave  : arbiter view (takes requests and memory response, drives
//            readies, read data, memory strobe/fields, stalls, bus_err)
//   master : environment view (requesters + memory)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              dm_rd;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [2:0]        dm_func3;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_func3;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  logic              stall_if;
  logic              stall_mem;
  logic              bus_err;

  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, dm_func3,
           mem_rdata, mem_rvalid,
    output if_rdata, if_ready, dm_rdata, dm_ready,
           mem_req, mem_we, mem_addr, mem_wdata, mem_func3,
           stall_if, stall_mem, bus_err
  );

  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, dm_func3,
           mem_rdata, mem_rvalid,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
           mem_req, mem_we, mem_addr, mem_wdata, mem_func3,
           stall_if, stall_mem, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter_lat_timer.sv
// Wait-cycle counter for the arbiter's response timeout.
//   clk, reset : clock, synchronous active-high reset
//   clear      : force count to zero (priority over enable)
//   enable     : count one more wait cycle
//   expired    : count has reached TIMEOUT (counter then holds)
module lat_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  assign expired = (count_q == CW'(TIMEOUT));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data requests win; loads and fetches wait for mem_rvalid or a timeout.
//   clk, reset : clock, synchronous active-high reset
//   bus        : requester handshakes (if_*, dm_*), memory request/response
//                (mem_*), per-requester stalls and sticky bus_err
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ARB_ADDR_W,
  parameter int unsigned DATA_W  = ARB_DATA_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);
  arb_state_t state_q, state_d;
  mem_req_t   req_q, req_d;
  logic       bus_err_q, bus_err_d;

  logic              tmr_clear, tmr_en, tmr_expired;
  logic              data_req;
  logic              m_req, m_we, if_rdy, dm_rdy;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, rsp_data;
  logic [2:0]        m_func3;

  assign data_req = bus.dm_rd | bus.dm_wr;

  lat_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    bus_err_d = bus_err_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_func3   = '0;
    if_rdy    = 1'b0;
    dm_rdy    = 1'b0;
    rsp_data  = '0;
    unique case (state_q)
      IDLE: begin
        tmr_clear = 1'b1;
        if (data_req) begin
          m_req   = 1'b1;
          m_we    = bus.dm_wr;
          m_addr  = bus.dm_addr;
          m_wdata = bus.dm_wdata;
          m_func3 = bus.dm_func3;
          if (bus.dm_wr) begin
            dm_rdy = 1'b1;
          end else begin
            state_d     = LOAD_WAIT;
            req_d.we    = 1'b0;
            req_d.addr  = bus.dm_addr;
            req_d.wdata = bus.dm_wdata;
            req_d.func3 = bus.dm_func3;
          end
        end else if (bus.if_req) begin
          m_req       = 1'b1;
          m_addr      = bus.if_addr;
          m_func3     = FETCH_FUNC3;
          state_d     = FETCH_WAIT;
          req_d.we    = 1'b0;
          req_d.addr  = bus.if_addr;
          req_d.wdata = '0;
          req_d.func3 = FETCH_FUNC3;
        end
      end
      FETCH_WAIT, LOAD_WAIT: begin
        m_req   = 1'b1;
        m_we    = req_q.we;
        m_addr  = req_q.addr;
        m_wdata = req_q.wdata;
        m_func3 = req_q.func3;
        // A response arriving on the expiry cycle still delivers its data.
        if (bus.mem_rvalid || tmr_expired) begin
          state_d  = IDLE;
          rsp_data = bus.mem_rvalid ? bus.mem_rdata : '0;
          if (!bus.mem_rvalid) bus_err_d = 1'b1;
          if (state_q == FETCH_WAIT) if_rdy = 1'b1;
          else                       dm_rdy = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Every output is held quiet while reset is asserted, even mid-wait.
  assign bus.mem_req   = m_req & ~reset;
  assign bus.mem_we    = m_we & ~reset;
  assign bus.mem_addr  = reset ? '0 : m_addr;
  assign bus.mem_wdata = reset ? '0 : m_wdata;
  assign bus.mem_func3 = reset ? '0 : m_func3;
  assign bus.if_ready  = if_rdy & ~reset;
  assign bus.dm_ready  = dm_rdy & ~reset;
  assign bus.if_rdata  = (if_rdy && !reset) ? rsp_data : '0;
  assign bus.dm_rdata  = (dm_rdy && !reset) ? rsp_data : '0;
  assign bus.stall_if  = bus.if_req & ~if_rdy & ~reset;
  assign bus.stall_mem = data_req & ~dm_rdy & ~reset;
  assign bus.bus_err   = bus_err_q & ~reset;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int TO = 4;
  localparam logic [2:0] TB_FETCH_F3 = 3'b010;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: at most one outstanding read, timed by elapsed cycles.
  bit          m_busy  = 1'b0;
  bit          m_load  = 1'b0;
  bit          m_err   = 1'b0;
  logic [8:0]  m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [2:0]  m_f3    = '0;
  int          m_issue = 0;

  // Memory behaviour
  int          rv_due   = -1;
  int          mem_lat  = 1;
  bit          stale_en = 1'b0;
  bit          rnd_data = 1'b0;
  logic [31:0] rd_val   = '0;

  bit exp_ifr = 1'b0;
  bit exp_dmr = 1'b0;

  int          dut_if_cnt = 0, dut_if_cyc = -1, dut_dm_cnt = 0, dut_dm_cyc = -1;
  logic [31:0] dut_if_data = '0, dut_dm_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: entered at a falling edge with inputs already driven.
  task automatic tick();
    bit          e_req, e_we, e_ifr, e_dmr, issue, finish;
    logic [8:0]  e_addr;
    logic [31:0] e_wd, e_ifd, e_dmd;
    logic [2:0]  e_f3;
    bus.mem_rvalid = (cyc == rv_due) || (stale_en && ($urandom_range(9) == 0));
    bus.mem_rdata  = rnd_data ? $urandom : rd_val;
    #2;
    e_req = 0; e_we = 0; e_ifr = 0; e_dmr = 0; issue = 0; finish = 0;
    e_addr = '0; e_wd = '0; e_ifd = '0; e_dmd = '0; e_f3 = '0;
    if (!reset) begin
      if (!m_busy) begin
        if (bus.dm_rd || bus.dm_wr) begin
          e_req = 1; e_we = bus.dm_wr; e_addr = bus.dm_addr;
          e_wd = bus.dm_wdata; e_f3 = bus.dm_func3;
          e_dmr = bus.dm_wr; issue = !bus.dm_wr;
        end else if (bus.if_req) begin
          e_req = 1; e_addr = bus.if_addr; e_f3 = TB_FETCH_F3; issue = 1;
        end
      end else begin
        e_req = 1; e_addr = m_addr; e_wd = m_wdata; e_f3 = m_f3;
        finish = bus.mem_rvalid || (cyc - m_issue == TO + 1);
        if (finish) begin
          if (m_load) begin e_dmr = 1; e_dmd = bus.mem_rvalid ? bus.mem_rdata : '0; end
          else        begin e_ifr = 1; e_ifd = bus.mem_rvalid ? bus.mem_rdata : '0; end
        end
      end
    end
    chk("mem_req",   32'(bus.mem_req),   32'(e_req));
    chk("mem_we",    32'(bus.mem_we),    32'(e_we));
    chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
    chk("mem_wdata", bus.mem_wdata,      e_wd);
    chk("mem_func3", 32'(bus.mem_func3), 32'(e_f3));
    chk("if_ready",  32'(bus.if_ready),  32'(e_ifr));
    chk("if_rdata",  bus.if_rdata,       e_ifd);
    chk("dm_ready",  32'(bus.dm_ready),  32'(e_dmr));
    chk("dm_rdata",  bus.dm_rdata,       e_dmd);
    chk("stall_if",  32'(bus.stall_if),  32'(bus.if_req & ~e_ifr & ~reset));
    chk("stall_mem", 32'(bus.stall_mem), 32'((bus.dm_rd | bus.dm_wr) & ~e_dmr & ~reset));
    chk("bus_err",   32'(bus.bus_err),   32'(m_err & ~reset));
    if (bus.if_ready) begin dut_if_cnt++; dut_if_cyc = cyc; dut_if_data = bus.if_rdata; end
    if (bus.dm_ready) begin dut_dm_cnt++; dut_dm_cyc = cyc; dut_dm_data = bus.dm_rdata; end
    exp_ifr = e_ifr;
    exp_dmr = e_dmr;
    if (reset) begin
      m_busy = 0; m_err = 0;
    end else if (issue) begin
      m_busy = 1; m_load = bus.dm_rd || bus.dm_wr;
      m_addr = e_addr; m_wdata = e_wd; m_f3 = e_f3; m_issue = cyc;
      rv_due = (mem_lat > 0) ? cyc + mem_lat : -1;
    end else if (finish) begin
      m_busy = 0;
      if (!bus.mem_rvalid) m_err = 1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Run cycles, dropping each request after its ready, until none remain.
  task automatic serve(input int max);
    int k = 0;
    while ((bus.if_req || bus.dm_rd || bus.dm_wr) && k < max) begin
      tick();
      k++;
      if (exp_dmr) begin bus.dm_rd = 0; bus.dm_wr = 0; end
      if (exp_ifr) bus.if_req = 0;
    end
    chk("serve_bound", 32'(bus.if_req || bus.dm_rd || bus.dm_wr), 32'(0));
    bus.if_req = 0; bus.dm_rd = 0; bus.dm_wr = 0;
  endtask

  task automatic drive_random();
    int k;
    if (exp_dmr) begin bus.dm_rd = 0; bus.dm_wr = 0; end
    if (exp_ifr) bus.if_req = 0;
    reset = ($urandom_range(199) == 0);
    if (reset) begin
      bus.if_req = 0; bus.dm_rd = 0; bus.dm_wr = 0;
    end else begin
      if (!(bus.dm_rd || bus.dm_wr) && $urandom_range(2) == 0) begin
        k = $urandom_range(3);
        bus.dm_rd    = (k != 1);
        bus.dm_wr    = (k == 1) || (k == 2);
        bus.dm_addr  = 9'($urandom);
        bus.dm_wdata = $urandom;
        bus.dm_func3 = 3'($urandom);
      end
      if (!bus.if_req && $urandom_range(1) == 0) begin
        bus.if_req  = 1;
        bus.if_addr = 9'($urandom) & 9'h1FC;
      end
    end
    mem_lat = $urandom_range(6);
  endtask

  initial begin
    int c0, n0, m0;
    bus.if_req = 0; bus.if_addr = '0; bus.dm_rd = 0; bus.dm_wr = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_func3 = '0;
    bus.mem_rdata = '0; bus.mem_rvalid = 0;
    reset = 1;
    @(negedge clk);
    tick();
    bus.dm_rd = 1; bus.if_req = 1;
    tick();
    bus.dm_rd = 0; bus.if_req = 0;
    reset = 0;
    tick();

    // Store: completes in its issue cycle
    c0 = cyc; n0 = dut_dm_cnt;
    bus.dm_wr = 1; bus.dm_addr = 9'h010; bus.dm_wdata = 32'hDEADBEEF; bus.dm_func3 = 3'b010;
    serve(4);
    chk("store_ready_cycle", 32'(dut_dm_cyc - c0), 32'(0));
    chk("store_ready_count", 32'(dut_dm_cnt - n0), 32'(1));

    // Load, response three cycles after issue
    mem_lat = 3; rd_val = 32'h12345678; c0 = cyc; n0 = dut_dm_cnt;
    bus.dm_rd = 1; bus.dm_addr = 9'h020; bus.dm_wdata = '0; bus.dm_func3 = 3'b010;
    serve(10);
    chk("load_ready_cycle", 32'(dut_dm_cyc - c0), 32'(3));
    chk("load_ready_count", 32'(dut_dm_cnt - n0), 32'(1));
    chk("load_rdata", dut_dm_data, 32'h12345678);

    // Fetch and load together: load first, fetch on the next idle cycle
    mem_lat = 1; rd_val = 32'hA5A50001; c0 = cyc;
    bus.if_req = 1; bus.if_addr = 9'h004; bus.dm_rd = 1; bus.dm_addr = 9'h030;
    serve(10);
    chk("conflict_load_cycle", 32'(dut_dm_cyc - c0), 32'(1));
    chk("conflict_fetch_cycle", 32'(dut_if_cyc - c0), 32'(3));
    chk("conflict_fetch_data", dut_if_data, 32'hA5A50001);

    // Fetch with no response at all
    mem_lat = 0; c0 = cyc;
    bus.if_req = 1; bus.if_addr = 9'h008;
    serve(12);
    chk("timeout_cycle", 32'(dut_if_cyc - c0), 32'(TO + 1));
    chk("timeout_rdata", dut_if_data, 32'h0);
    chk("timeout_bus_err", 32'(bus.bus_err), 32'(1));
    n0 = dut_if_cnt; m0 = dut_dm_cnt;
    rv_due = cyc; tick();
    rv_due = cyc; tick();
    chk("late_rvalid_ready", 32'((dut_if_cnt - n0) + (dut_dm_cnt - m0)), 32'(0));

    // Reset while a load waits
    mem_lat = 3; bus.dm_rd = 1; bus.dm_addr = 9'h040;
    tick(); tick();
    reset = 1; bus.dm_rd = 0; n0 = dut_dm_cnt;
    tick();
    reset = 0;
    tick();
    chk("reset_no_ready", 32'(dut_dm_cnt - n0), 32'(0));
    chk("reset_bus_err", 32'(bus.bus_err), 32'(0));
    mem_lat = 2; rd_val = 32'h0BADF00D; c0 = cyc;
    bus.dm_rd = 1; bus.dm_addr = 9'h044;
    serve(10);
    chk("post_reset_load_cycle", 32'(dut_dm_cyc - c0), 32'(2));
    chk("post_reset_load_data", dut_dm_data, 32'h0BADF00D);

    // Back-to-back fetches
    mem_lat = 1; n0 = dut_if_cnt;
    for (int i = 0; i < 4; i++) begin
      rd_val = 32'h100 + 32'(i);
      bus.if_req = 1; bus.if_addr = 9'(16 * i);
      serve(6);
    end
    chk("b2b_count", 32'(dut_if_cnt - n0), 32'(4));
    chk("b2b_last_data", dut_if_data, 32'h103);

    // Random traffic against the model
    stale_en = 1; rnd_data = 1;
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
